// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register-set write port; registered one-hot write controls.
// Optional macro RF_WR_R0_PROTECT_EN suppresses writes to register 0 and flags them on r0_viol_o.
module rf_write_arbiter #(
  parameter int W_width = 32,
  parameter int NREQ    = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*3-1:0]       req_addr_i,
  input  logic [NREQ*W_width-1:0] req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    hold_i,
  output logic                    regWrite_o,
  output logic [7:0]              decOut_o,
  output logic [W_width-1:0]      writeData_o,
  output logic [2:0]              grant_id_o,
`ifdef RF_WR_R0_PROTECT_EN
  output logic                    r0_viol_o,
`endif
  output logic                    busy_o
);
  logic [2:0]         ptr_q, ptr_d;
  logic               wr_q, wr_d;
  logic [7:0]         dec_q, dec_d;
  logic [W_width-1:0] wdata_q, wdata_d;
  logic [2:0]         gid_q, gid_d;
  logic [NREQ-1:0]    gnt;
  logic [2:0]         gnt_idx;
  logic [2:0]         sel_addr;
  logic               found;
  logic               wr_ok;
  int                 idx;
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k >= NREQ) ? int'(ptr_q) + k - NREQ : int'(ptr_q) + k;
      if (!found && req_valid_i[idx] && !hold_i && RST) begin
        found     = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = 3'(idx);
      end
    end
  end
  assign sel_addr = req_addr_i[3*int'(gnt_idx) +: 3];
`ifdef RF_WR_R0_PROTECT_EN
  logic viol_q, viol_d;
  assign wr_ok     = sel_addr != 3'd0;
  assign viol_d    = viol_q | (found & ~wr_ok);
  assign r0_viol_o = viol_q;
`else
  assign wr_ok = 1'b1;
`endif
  always_comb begin
    ptr_d   = found ? ((gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1) : ptr_q;
    wr_d    = found & wr_ok;
    dec_d   = (found && wr_ok) ? 8'd1 << sel_addr : 8'h00;
    wdata_d = found ? req_data_i[W_width*int'(gnt_idx) +: W_width] : wdata_q;
    gid_d   = found ? gnt_idx : gid_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      dec_q   <= 8'h00;
      wdata_q <= '0;
      gid_q   <= '0;
`ifdef RF_WR_R0_PROTECT_EN
      viol_q  <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      dec_q   <= dec_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
`ifdef RF_WR_R0_PROTECT_EN
      viol_q  <= viol_d;
`endif
    end
  end
  assign req_ready_o = gnt;
  assign busy_o      = |(req_valid_i & ~gnt);
  assign regWrite_o  = wr_q;
  assign decOut_o    = dec_q;
  assign writeData_o = wdata_q;
  assign grant_id_o  = gid_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter (NREQ=3, W_width=32).
module tb_rf_write_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  valid;
  logic [8:0]  addr;
  logic [95:0] data;
  logic        hold;
  logic [2:0]  ready;
  logic        reg_write;
  logic [7:0]  dec_out;
  logic [31:0] wdata;
  logic [2:0]  gid;
  logic        busy;
`ifdef RF_WR_R0_PROTECT_EN
  logic        r0_viol;
`endif
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  rf_write_arbiter #(.W_width(32), .NREQ(3)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
    .req_ready_o(ready), .hold_i(hold),
    .regWrite_o(reg_write), .decOut_o(dec_out), .writeData_o(wdata),
    .grant_id_o(gid),
`ifdef RF_WR_R0_PROTECT_EN
    .r0_viol_o(r0_viol),
`endif
    .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RST = 1'b0; valid = 3'b111; addr = '0; data = '0; hold = 1'b0;
    #3;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_wr", reg_write, 0);
    chk("rst_dec", dec_out, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_gid", gid, 0);
    step();
    chk("rst_hold_wr", reg_write, 0);
    valid = 3'b000;
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_ready", ready, 0);
      chk("idle_busy", busy, 0);
      step();
      chk("idle_wr", reg_write, 0);
      chk("idle_dec", dec_out, 0);
    end
    // all three valid from pointer 0: strict rotation 0,1,2,0,1,2
    valid = 3'b111;
    addr  = {3'd3, 3'd2, 3'd1};
    data  = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", ready, 64'(3'b001 << (k % 3)));
      chk("rr_busy", busy, 1);
      step();
      chk("rr_wr", reg_write, 1);
      chk("rr_dec", dec_out, 64'(8'h02 << (k % 3)));
      chk("rr_gid", gid, 64'(k % 3));
      chk("rr_wdata", wdata, 64'(32'h100 + k % 3));
    end
    valid = 3'b000;
    step();
    chk("rr_end_wr", reg_write, 0);
    chk("rr_end_dec", dec_out, 0);
    chk("rr_end_wdata_hold", wdata, 32'h102);
    chk("rr_end_gid_hold", gid, 2);
    valid = 3'b010;
    addr  = {3'd7, 3'd5, 3'd0};
    data  = {32'h0000_0077, 32'hDEAD_BEEF, 32'h0000_0001};
    #1;
    chk("single_ready", ready, 3'b010);
    chk("single_busy", busy, 0);
    step();
    valid = 3'b000;
    chk("single_wr", reg_write, 1);
    chk("single_dec", dec_out, 8'b0010_0000);
    chk("single_wdata", wdata, 32'hDEAD_BEEF);
    chk("single_gid", gid, 1);
    step();
    chk("single_after_wr", reg_write, 0);
    chk("single_after_wdata", wdata, 32'hDEAD_BEEF);
    hold  = 1'b1;
    valid = 3'b100;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_ready", ready, 0);
      chk("hold_busy", busy, 1);
      step();
      chk("hold_wr", reg_write, 0);
    end
    hold = 1'b0;
    #1;
    chk("unhold_ready", ready, 3'b100);
    chk("unhold_busy", busy, 0);
    step();
    valid = 3'b000;
    chk("unhold_wr", reg_write, 1);
    chk("unhold_dec", dec_out, 8'h80);
    chk("unhold_gid", gid, 2);
    chk("unhold_wdata", wdata, 32'h77);
    // pointer is 0: grant 0 moves it to 1, then reset must bring it back
    valid = 3'b001;
    #1;
    chk("pre_rst_ready", ready, 3'b001);
    step();
    chk("pre_rst_wr", reg_write, 1);
    chk("pre_rst_gid", gid, 0);
    #1;
    chk("rstgnt_ready", ready, 3'b001);
    RST = 1'b0;
    #1;
    chk("rstgnt_async_wr", reg_write, 0);
    chk("rstgnt_ready_low", ready, 0);
    chk("rstgnt_async_dec", dec_out, 0);
    step();
    chk("rstgnt_wr", reg_write, 0);
    chk("rstgnt_wdata", wdata, 0);
    RST = 1'b1;
    valid = 3'b011;
    #1;
    chk("post_rst_ready", ready, 3'b001);
    step();
    valid = 3'b000;
    chk("post_rst_wr", reg_write, 1);
    chk("post_rst_gid", gid, 0);
    chk("post_rst_dec", dec_out, 8'h01);
    step();
    valid = 3'b001;
    addr  = 9'd0;
    data  = 96'h1;
    #1;
    chk("r0_ready", ready, 3'b001);
    step();
    valid = 3'b000;
`ifdef RF_WR_R0_PROTECT_EN
    chk("r0_wr", reg_write, 0);
    chk("r0_dec", dec_out, 0);
    chk("r0_viol", r0_viol, 1);
    step();
    step();
    chk("r0_viol_sticky", r0_viol, 1);
    RST = 1'b0;
    #1;
    chk("r0_viol_rst", r0_viol, 0);
    RST = 1'b1;
`else
    chk("r0_wr", reg_write, 1);
    chk("r0_dec", dec_out, 8'h01);
    chk("r0_wdata", wdata, 1);
`endif
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-set write port (regWrite, 8-way one-hot decode select, writeData) between NREQ independent write requesters, e.g. ALU writeback, load unit and debug port.
- Arbitrates each cycle with a rotating round-robin pointer.
- Registers the winning request and drives the register set's write controls one cycle later.
- Sits between the writeback sources and the register set; it produces the one-hot decode directly, so no separate decoder is needed.

Parameters:
W_width, 32, data width of each write request and of writeData_o
NREQ, 3, number of write requesters (2..8)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous active-low reset
req_valid_i  input  NREQ  per-requester write request valid
req_addr_i  input  NREQ*3  packed register indices; requester i uses bits [3i+2:3i]
req_data_i  input  NREQ*W_width  packed write data; requester i uses bits [W_width*i +: W_width]
req_ready_o  output  NREQ  one-hot grant; combinational; requester i's request is accepted in a cycle where valid[i] and ready[i] are both high
hold_i  input  1  datapath freeze; while high, no grant is issued
regWrite_o  output  1  write strobe to the register set
decOut_o  output  8  one-hot register select to the register set
writeData_o  output  W_width  write data to the register set
grant_id_o  output  3  index of the requester whose write is on the port this cycle
busy_o  output  1  high when any req_valid_i is high and not granted this cycle

Behaviour:
- Reset (RST low, asynchronous): regWrite_o=0, decOut_o=8'h00, writeData_o=0, grant_id_o=0, round-robin pointer=0. req_ready_o=0 while RST is low.
- Reset mid-operation: a request granted in the cycle reset asserts is dropped. Its write never reaches the register set.
- Arbitration (combinational, every cycle):
  - If hold_i=1 or no valid is high: req_ready_o=0.
  - Otherwise search from pointer p upward, wrapping modulo NREQ. The first i with req_valid_i[i]=1 gets req_ready_o[i]=1.
  - Exactly one grant per cycle at most.
- Pointer: on a grant to i, p <= (i+1) mod NREQ. With no grant, p is unchanged.
- Output register, one-cycle latency: on a grant to i at edge t, at edge t the block loads:
  - regWrite_o=1
  - decOut_o = 1 << req_addr_i[i]
  - writeData_o = req_data_i[i]
  - grant_id_o = i
  With no grant, regWrite_o=0, decOut_o=8'h00, and writeData_o/grant_id_o hold their last values.
- Back-to-back grants give one write per cycle. Throughput is 1 write/cycle.
- Fairness: a continuously valid requester is granted within NREQ cycles when hold_i=0.
- Requesters must hold valid, addr and data stable until ready. The block does not buffer unaccepted requests.
- Same register addressed by consecutive grants: the writes land in grant order, so the later one wins.
- hold_i does not cancel a write already registered. The registered write still drives the port in the next cycle.
- busy_o = |req_valid_i & ~(req_ready_o has a bit set for that requester). It is combinational.
- req_addr_i values 0..7 are all legal. There is no write protection unless the optional feature is enabled.

Optional Feature:
Macro RF_WR_R0_PROTECT_EN.
- Defined:
  - A request with addr 3'd0 is still granted and consumes its round-robin turn.
  - The registered write has regWrite_o=0 and decOut_o=8'h00, so register 0 is never written.
  - A sticky output r0_viol_o (1 bit) sets on such a grant and clears only on reset.
- Not defined: no r0_viol_o port, and address 0 is written like any other register.

Test Plan:
- Reset then idle: all req_valid_i=0 -> regWrite_o=0, decOut_o=8'h00, req_ready_o=0 for 10 cycles.
- Single request: valid[1]=1, addr=3'd5, data=32'hDEADBEEF -> ready[1]=1 in the same cycle; next cycle regWrite_o=1, decOut_o=8'b0010_0000, writeData_o=32'hDEADBEEF, grant_id_o=1.
- All three valid continuously, addrs 1/2/3 -> grants in the order 0,1,2,0,1,2. decOut_o follows 8'h02, 8'h04, 8'h08, repeating. regWrite_o stays high every cycle.
- hold_i=1 for 4 cycles with valid[2]=1 -> no ready and busy_o=1 during hold. Grant is issued in the first cycle hold_i=0.
- Grant to requester 0 in the same cycle RST falls -> regWrite_o=0 after reset and pointer=0. The next grant goes to the lowest valid index.
- RF_WR_R0_PROTECT_EN defined: valid[0]=1, addr=0, data=32'h1 -> ready[0]=1; next cycle regWrite_o=0 and r0_viol_o=1, and it stays 1 until reset.
